// File: rtl/fighter_core.sv
// Per-player fighter controller: input sync, attack/stun phase timing and
// saturated horizontal movement, all advanced once per game-frame tick.
module fighter_core #(
    parameter logic [9:0] INIT_X           = 10'd400,
    parameter bit         FACING_LEFT      = 1'b0,
    parameter logic [9:0] X_MIN            = 10'd0,
    parameter logic [9:0] X_MAX            = 10'd576,
    parameter int         FWD_STEP         = 3,
    parameter int         BWD_STEP         = 2,
    parameter int         BASIC_STARTUP    = 5,
    parameter int         BASIC_ACTIVE     = 2,
    parameter int         BASIC_RECOVERY   = 16,
    parameter int         DIR_STARTUP      = 4,
    parameter int         DIR_ACTIVE       = 3,
    parameter int         DIR_RECOVERY     = 15,
    parameter int         HITSTUN_FRAMES   = 12,
    parameter int         BLOCKSTUN_FRAMES = 6,
    parameter int         KNOCKBACK        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       fwd,
    input  logic       bwd,
    input  logic       attack,
    input  logic       hit_in,
    output logic [3:0] state,
    output logic       attacking,
    output logic       hitbox_active,
    output logic       hurt_extended,
    output logic [9:0] pos_x,
    output logic [4:0] frame_cnt,
    output logic       hit_taken,
    output logic       block_taken
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_MOV_F     = 4'd1,
        S_MOV_B     = 4'd2,
        S_B_START   = 4'd3,
        S_B_ACT     = 4'd4,
        S_B_REC     = 4'd5,
        S_D_START   = 4'd6,
        S_D_ACT     = 4'd7,
        S_D_REC     = 4'd8,
        S_HITSTUN   = 4'd9,
        S_BLOCKSTUN = 4'd10
    } state_t;

    localparam logic [4:0] BS_LOAD = 5'(BASIC_STARTUP - 1);
    localparam logic [4:0] BA_LOAD = 5'(BASIC_ACTIVE - 1);
    localparam logic [4:0] BR_LOAD = 5'(BASIC_RECOVERY - 1);
    localparam logic [4:0] DS_LOAD = 5'(DIR_STARTUP - 1);
    localparam logic [4:0] DA_LOAD = 5'(DIR_ACTIVE - 1);
    localparam logic [4:0] DR_LOAD = 5'(DIR_RECOVERY - 1);
    localparam logic [4:0] HS_LOAD = 5'(HITSTUN_FRAMES - 1);
    localparam logic [4:0] KS_LOAD = 5'(BLOCKSTUN_FRAMES - 1);

    // Signed deltas already resolved for facing: "backward" is away from the opponent.
    localparam logic signed [10:0] FWD_DELTA = FACING_LEFT ? -11'(FWD_STEP)  : 11'(FWD_STEP);
    localparam logic signed [10:0] BWD_DELTA = FACING_LEFT ?  11'(BWD_STEP)  : -11'(BWD_STEP);
    localparam logic signed [10:0] KB_DELTA  = FACING_LEFT ?  11'(KNOCKBACK) : -11'(KNOCKBACK);

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [9:0]  pos_reg, pos_next;
    logic        fwd_reg, bwd_reg, atk_reg, atk_prev_reg;
    logic        hit_pending_reg;
    logic        hit_taken_reg, hit_next;
    logic        block_taken_reg, block_next;

    logic signed [10:0] delta;
    logic signed [10:0] pos_sum;
    logic               hit_now, atk_edge, fwd_only, bwd_only;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        delta      = '0;
        hit_next   = 1'b0;
        block_next = 1'b0;
        hit_now    = hit_pending_reg | hit_in;
        atk_edge   = atk_reg & ~atk_prev_reg;
        fwd_only   = fwd_reg & ~bwd_reg;
        bwd_only   = bwd_reg & ~fwd_reg;

        if (frame_tick) begin
            if (hit_now && state_reg != S_HITSTUN && state_reg != S_BLOCKSTUN) begin
                delta = KB_DELTA;
                if ((state_reg == S_IDLE || state_reg == S_MOV_B) && bwd_only) begin
                    state_next = S_BLOCKSTUN;
                    cnt_next   = KS_LOAD;
                    block_next = 1'b1;
                end else begin
                    state_next = S_HITSTUN;
                    cnt_next   = HS_LOAD;
                    hit_next   = 1'b1;
                end
            end else begin
                case (state_reg)
                    S_IDLE, S_MOV_F, S_MOV_B: begin
                        cnt_next = '0;
                        if (atk_edge) begin
                            // A single direction held selects the directional attack.
                            state_next = (fwd_reg ^ bwd_reg) ? S_D_START : S_B_START;
                            cnt_next   = (fwd_reg ^ bwd_reg) ? DS_LOAD : BS_LOAD;
                        end else if (fwd_only) begin
                            state_next = S_MOV_F;
                            delta      = FWD_DELTA;
                        end else if (bwd_only) begin
                            state_next = S_MOV_B;
                            delta      = BWD_DELTA;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                    S_B_START: begin
                        if (cnt_reg == 5'd0) begin state_next = S_B_ACT; cnt_next = BA_LOAD; end
                        else cnt_next = cnt_reg - 5'd1;
                    end
                    S_B_ACT: begin
                        if (cnt_reg == 5'd0) begin state_next = S_B_REC; cnt_next = BR_LOAD; end
                        else cnt_next = cnt_reg - 5'd1;
                    end
                    S_D_START: begin
                        if (cnt_reg == 5'd0) begin state_next = S_D_ACT; cnt_next = DA_LOAD; end
                        else cnt_next = cnt_reg - 5'd1;
                    end
                    S_D_ACT: begin
                        if (cnt_reg == 5'd0) begin state_next = S_D_REC; cnt_next = DR_LOAD; end
                        else cnt_next = cnt_reg - 5'd1;
                    end
                    S_B_REC, S_D_REC, S_HITSTUN, S_BLOCKSTUN: begin
                        if (cnt_reg == 5'd0) begin state_next = S_IDLE; cnt_next = '0; end
                        else cnt_next = cnt_reg - 5'd1;
                    end
                    default: begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end
        end

        // Moves are clamped to the arena rather than refused.
        pos_sum = $signed({1'b0, pos_reg}) + delta;
        if (pos_sum < $signed({1'b0, X_MIN}))
            pos_next = X_MIN;
        else if (pos_sum > $signed({1'b0, X_MAX}))
            pos_next = X_MAX;
        else
            pos_next = pos_sum[9:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            pos_reg         <= INIT_X;
            fwd_reg         <= 1'b0;
            bwd_reg         <= 1'b0;
            atk_reg         <= 1'b0;
            atk_prev_reg    <= 1'b0;
            hit_pending_reg <= 1'b0;
            hit_taken_reg   <= 1'b0;
            block_taken_reg <= 1'b0;
        end else begin
            fwd_reg         <= fwd;
            bwd_reg         <= bwd;
            atk_reg         <= attack;
            hit_taken_reg   <= hit_next;
            block_taken_reg <= block_next;
            // A hit latched between ticks is consumed by the next tick, hit or not.
            hit_pending_reg <= frame_tick ? 1'b0 : (hit_pending_reg | hit_in);
            if (frame_tick) begin
                atk_prev_reg <= atk_reg;
                state_reg    <= state_next;
                cnt_reg      <= cnt_next;
                pos_reg      <= pos_next;
            end
        end
    end

    assign state         = state_reg;
    assign pos_x         = pos_reg;
    assign frame_cnt     = cnt_reg;
    assign hit_taken     = hit_taken_reg;
    assign block_taken   = block_taken_reg;
    assign attacking     = (state_reg >= S_B_START) && (state_reg <= S_D_REC);
    assign hitbox_active = (state_reg == S_B_ACT) || (state_reg == S_D_ACT);
    assign hurt_extended = (state_reg == S_B_REC) || (state_reg == S_D_REC);

endmodule

// File: doc/fighter_core.md
Name: fighter_core

Overview:
- Parametrised next-generation fighter controller: the per-player state machine, movement and combat timing core for the two-player VGA fight game.
- Generalises the fixed per-character controllers with configurable facing, frame data, step sizes, hit/block stun and knockback.
- Advances only on a game-frame tick, not on every clock.
- Sits between the synchronised button inputs and the renderer/collision logic; outputs position and combat flags only. No pixel generation.

Parameters:
- INIT_X, 10'd400, reset x position; must lie in [X_MIN, X_MAX].
- FACING_LEFT, 0, 0: fwd increases x; 1: fwd decreases x.
- X_MIN, 10'd0, leftmost legal x.
- X_MAX, 10'd576, rightmost legal x.
- FWD_STEP, 3, pixels moved per tick when moving forward.
- BWD_STEP, 2, pixels moved per tick when moving backward.
- BASIC_STARTUP / BASIC_ACTIVE / BASIC_RECOVERY, 5 / 2 / 16, basic attack phase lengths in ticks; each must be in [1, 31].
- DIR_STARTUP / DIR_ACTIVE / DIR_RECOVERY, 4 / 3 / 15, directional attack phase lengths in ticks; each must be in [1, 31].
- HITSTUN_FRAMES, 12, hitstun length in ticks.
- BLOCKSTUN_FRAMES, 6, blockstun length in ticks.
- KNOCKBACK, 8, pixels pushed backward on stun entry.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per game frame.
- fwd  in  1  forward button.
- bwd  in  1  backward button.
- attack  in  1  attack button.
- hit_in  in  1  one-cycle pulse: opponent hitbox overlapped this player's hurtbox.
- state  out  4  0 IDLE, 1 MOV_F, 2 MOV_B, 3 B_START, 4 B_ACT, 5 B_REC, 6 D_START, 7 D_ACT, 8 D_REC, 9 HITSTUN, 10 BLOCKSTUN.
- attacking  out  1  high when state is in 3..8.
- hitbox_active  out  1  high when state is 4 or 7.
- hurt_extended  out  1  high when state is 5 or 8.
- pos_x  out  10  current x position.
- frame_cnt  out  5  remaining ticks in the current phase, minus 1.
- hit_taken  out  1  one-cycle pulse on HITSTUN entry.
- block_taken  out  1  one-cycle pulse on BLOCKSTUN entry.

Behaviour:
- Reset (synchronous, rst high at a clk edge): state=0, pos_x=INIT_X, frame_cnt=0. All pulses, flags, sync registers, attack edge detector and hit_pending are cleared. rst overrides frame_tick and hit_in on the same edge.
- fwd, bwd and attack pass through one register stage; all decisions use the registered copies.
- atk_edge = registered attack AND NOT the previous registered attack. It is evaluated on frame_tick cycles only; the "previous" value updates only on ticks. A held button never re-triggers an attack.
- hit_in on any cycle sets hit_pending. hit_pending is consumed and cleared on the next frame_tick. hit_in arriving on a tick cycle is consumed on that same tick.
- State, pos_x and frame_cnt change only on frame_tick cycles.
- Phase timing: entering a phase of length N loads frame_cnt=N-1. Each tick decrements frame_cnt; the tick with frame_cnt=0 transitions. Every phase therefore lasts exactly N ticks.
- Priority on a tick, highest first:
  1. Hit: if hit_pending and state is not 9/10, go to BLOCKSTUN when state is IDLE or MOV_B and registered bwd=1 and fwd=0; otherwise go to HITSTUN. This interrupts attacks at any phase. The matching pulse fires in the cycle after the tick.
  2. Attack: from IDLE, MOV_F or MOV_B, atk_edge goes to D_START if exactly one of fwd/bwd is held, else to B_START.
  3. Movement: from IDLE, MOV_F or MOV_B, fwd-only gives MOV_F, bwd-only gives MOV_B, otherwise IDLE.
- Phase chains: B_START→B_ACT→B_REC→IDLE; D_START→D_ACT→D_REC→IDLE; HITSTUN→IDLE; BLOCKSTUN→IDLE.
- hit_pending while already in HITSTUN or BLOCKSTUN is discarded; the stun is not extended.
- Movement applies on a tick whose resulting state is MOV_F or MOV_B. pos_x changes by ±FWD_STEP or ±BWD_STEP, direction per FACING_LEFT.
- Stun entry pushes pos_x backward by KNOCKBACK.
- Position arithmetic is done at 11 bits signed, then saturated to [X_MIN, X_MAX]. A move is never refused; it is clamped.
- Unused state codes 11..15 return to IDLE with frame_cnt=0 on the next tick.

Test Plan:
- Reset: rst for 2 clocks with hit_in=1 → state=0, pos_x=400, hit_taken=0.
- Forward move, FACING_LEFT=0: fwd held for 10 ticks → pos_x=430, state=1. Then fwd released → state=0 after 1 tick.
- Saturation: INIT_X=574, fwd held for 3 ticks → pos_x=576, state=1. Repeat with bwd at INIT_X=1 → pos_x=0.
- Basic attack: single attack press from IDLE → B_START for 5 ticks, B_ACT for 2 (hitbox_active=1), B_REC for 16 (hurt_extended=1), then IDLE. Attack held throughout → no second attack.
- Directional attack: bwd+attack → D_START 4, D_ACT 3, D_REC 15 ticks. hit_in during D_ACT → HITSTUN on next tick, hit_taken pulse, pos_x-=8, IDLE after 12 ticks.
- Block: bwd held in MOV_B with hit_in mid-frame (not on tick) → BLOCKSTUN on next tick, block_taken=1, 6 ticks. Second hit_in during BLOCKSTUN → ignored.
